// File: rtl/eq_dac_serializer.sv
// Output stage after the equalizer FIR. It shifts and saturates each 32-bit sample to a DAC
// word and buffers it in a small FIFO. The word is then sent MSB-first as a left-justified
// stereo frame, with the mono word repeated on left and right.
module eq_dac_serializer #(
  parameter int unsigned SHIFT      = 6,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] d_in,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sat,
  output logic [7:0]  sat_cnt,
  output logic        drop,
  output logic        fifo_full
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int MaxVal = 2 ** (OUT_W - 1) - 1;
  localparam int MinVal = -(2 ** (OUT_W - 1));

  typedef enum logic [1:0] {StIdle, StLeft, StRight} state_t;

  // Conditioning: arithmetic shift, then clamp to the signed DAC range
  logic signed [31:0] y;
  logic               clip_hi;
  logic               clip_lo;
  logic [OUT_W-1:0]   word_in;

  assign y       = $signed(d_in) >>> SHIFT;
  assign clip_hi = (y > MaxVal);
  assign clip_lo = (y < MinVal);

  // Select the saturated or truncated DAC word
  always_comb begin
    word_in = y[OUT_W-1:0];
    if (clip_hi) begin
      word_in = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (clip_lo) begin
      word_in = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

  // FIFO storage and control
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] head;

  assign empty     = (count == '0);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push      = sample_valid && (!fifo_full || pop);
  assign head      = mem[rd_ptr];

  // Sample storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered clip/drop flags and the saturating clip counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat     <= 1'b0;
      drop    <= 1'b0;
      sat_cnt <= 8'd0;
    end else begin
      sat  <= sample_valid && (clip_hi || clip_lo);
      drop <= sample_valid && !push;
      if (sample_valid && (clip_hi || clip_lo) && (sat_cnt != 8'hFF)) begin
        sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

  // Free-running bit-clock divider
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          fall;

  assign tick = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall = tick && bclk;

  // bclk toggles every BCLK_DIV cycles, starting low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Serializer state
  state_t           state;
  logic [IW-1:0]    bit_idx;
  logic [OUT_W-1:0] word;

  // Pop only at a frame boundary: from idle or after the last right-channel bit
  assign pop = fall && !empty &&
               ((state == StIdle) || ((state == StRight) && (bit_idx == '0)));

  // Frame sequencer; all outputs change only on bclk falling ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      bit_idx <= '0;
      word    <= '0;
      sdata   <= 1'b0;
      lrclk   <= 1'b0;
    end else if (fall) begin
      unique case (state)
        StIdle: begin
          if (!empty) begin
            state   <= StLeft;
            word    <= head;
            bit_idx <= IW'(OUT_W - 1);
            sdata   <= head[OUT_W-1];
            lrclk   <= 1'b0;
          end
        end
        StLeft: begin
          if (bit_idx == '0) begin
            state   <= StRight;
            bit_idx <= IW'(OUT_W - 1);
            sdata   <= word[OUT_W-1];
            lrclk   <= 1'b1;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            sdata   <= word[bit_idx-IW'(1)];
          end
        end
        StRight: begin
          if (bit_idx == '0) begin
            if (!empty) begin
              state   <= StLeft;
              word    <= head;
              bit_idx <= IW'(OUT_W - 1);
              sdata   <= head[OUT_W-1];
              lrclk   <= 1'b0;
            end else begin
              state <= StIdle;
              sdata <= 1'b0;
              lrclk <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx - IW'(1);
            sdata   <= word[bit_idx-IW'(1)];
          end
        end
        default: begin
          state <= StIdle;
          sdata <= 1'b0;
          lrclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_dac_serializer.sv
// Directed bench for eq_dac_serializer with default parameters (SHIFT=6, OUT_W=16,
// FIFO_DEPTH=4, BCLK_DIV=4).
module tb_eq_dac_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] d_in = '0;
  logic        bclk, lrclk, sdata, sat, drop, fifo_full;
  logic [7:0]  sat_cnt;

  int tests = 0;
  int fails = 0;
  int drop_seen = 0;

  eq_dac_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .d_in         (d_in),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .sat          (sat),
    .sat_cnt      (sat_cnt),
    .drop         (drop),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;

  // Running tally of drop pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (drop === 1'b1) drop_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the first negedge after a bclk 1->0 transition
  task automatic next_fall();
    logic p;
    bit   got;
    p   = bclk;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (p === 1'b1 && bclk === 1'b0) got = 1'b1;
      p = bclk;
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL bclk_timeout: observed no fall expected fall within 40 cycles");
    end
  endtask

  // One-cycle sample pulse, called at a negedge
  task automatic send(input logic [31:0] d);
    sample_valid = 1'b1;
    d_in         = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Capture 32 bits of one frame; optionally inject a sample after the first bit
  task automatic get_frame(input string tag, input logic [15:0] exp_w,
                           input logic inj, input logic [31:0] inj_d);
    logic [15:0] l, r;
    logic        lr_bad;
    l = '0;
    r = '0;
    lr_bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      next_fall();
      if (i < 16) l = {l[14:0], sdata};
      else        r = {r[14:0], sdata};
      if (lrclk !== ((i >= 16) ? 1'b1 : 1'b0)) lr_bad = 1'b1;
      if (i == 0 && inj) send(inj_d);
    end
    check({tag, "_left"}, {16'd0, l}, {16'd0, exp_w});
    check({tag, "_right"}, {16'd0, r}, {16'd0, exp_w});
    check({tag, "_lrclk_bad"}, {31'd0, lr_bad}, 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    next_fall();
    check(tag, {30'd0, lrclk, sdata}, 32'd0);
  endtask

  // Single-sample conditioning test with its frame and trailing idle
  task automatic one_sample(input string tag, input logic [31:0] d, input logic [15:0] exp_w,
                            input logic exp_sat, input logic [7:0] exp_cnt);
    next_fall();
    send(d);
    check({tag, "_sat"}, {31'd0, sat}, {31'd0, exp_sat});
    @(negedge clk);
    check({tag, "_sat_clear"}, {31'd0, sat}, 32'd0);
    check({tag, "_sat_cnt"}, {24'd0, sat_cnt}, {24'd0, exp_cnt});
    get_frame(tag, exp_w, 1'b0, 32'd0);
    expect_idle({tag, "_idle"});
  endtask

  initial begin
    int d0;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {18'd0, bclk, lrclk, sdata, sat, drop, fifo_full, sat_cnt}, 32'd0);
    rst = 1'b0;
    // Divider: rises after cycle 4, first fall tick in cycle 8
    repeat (3) @(negedge clk);
    check("bclk_low_c3", {31'd0, bclk}, 32'd0);
    @(negedge clk);
    check("bclk_high_c4", {31'd0, bclk}, 32'd1);
    repeat (3) @(negedge clk);
    check("bclk_high_c7", {31'd0, bclk}, 32'd1);
    @(negedge clk);
    check("bclk_fall_c8", {31'd0, bclk}, 32'd0);

    // Conditioning cases
    one_sample("s_0400",  32'h0001_0000, 16'h0400, 1'b0, 8'd0);
    one_sample("s_maxp",  32'h7FFF_FFFF, 16'h7FFF, 1'b1, 8'd1);
    one_sample("s_maxn",  32'h8000_0000, 16'h8000, 1'b1, 8'd2);
    one_sample("s_m64",   32'hFFFF_FFC0, 16'hFFFF, 1'b0, 8'd2);
    one_sample("s_m1",    32'hFFFF_FFFF, 16'hFFFF, 1'b0, 8'd2);
    one_sample("s_hi_ok", 32'h001F_FFFF, 16'h7FFF, 1'b0, 8'd2);
    one_sample("s_hi_sat", 32'h0020_0000, 16'h7FFF, 1'b1, 8'd3);
    one_sample("s_lo_ok", 32'hFFE0_0000, 16'h8000, 1'b0, 8'd3);

    // Burst of six samples right after reset: four stored, two dropped
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sample_valid = 1'b1;
      d_in = (32'(k) * 32'h111) << 6;
      check($sformatf("burst_full_%0d", k), {31'd0, fifo_full}, {31'd0, (k >= 5)});
      check($sformatf("burst_drop_%0d", k), {31'd0, drop}, {31'd0, (k == 6)});
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("burst_drop_6", {31'd0, drop}, 32'd1);
    @(negedge clk);
    check("burst_drop_clear", {31'd0, drop}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      get_frame($sformatf("burst_f%0d", k), 16'(k * 'h111), 1'b0, 32'd0);
    end
    expect_idle("burst_idle");
    check("burst_empty_full", {31'd0, fifo_full}, 32'd0);

    // Samples one frame apart: continuous frames, no drops
    d0 = drop_seen;
    next_fall();
    send(32'h1234 << 6);
    get_frame("sp_a", 16'h1234, 1'b1, 32'h0ABC << 6);
    get_frame("sp_b", 16'h0ABC, 1'b1, 32'h3C3C << 6);
    get_frame("sp_c", 16'h3C3C, 1'b1, 32'h5A5A << 6);
    next_fall();
    send(32'h7E7E << 6);
    repeat (19) next_fall();
    check("sp_no_drop", 32'(drop_seen - d0), 32'd0);
    check("pre_rst_right", {31'd0, lrclk}, 32'd1);

    // Reset mid-RIGHT: outputs clear immediately, queued word discarded
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {18'd0, bclk, lrclk, sdata, sat, drop, fifo_full, sat_cnt},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'h0F0F << 6);
    get_frame("post_rst", 16'h0F0F, 1'b0, 32'd0);
    expect_idle("post_rst_idle");

    // 300 clipping samples: counter saturates at 255
    sample_valid = 1'b1;
    d_in = 32'h7FFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 253) check("satcnt_254", {24'd0, sat_cnt}, 32'd254);
    end
    sample_valid = 1'b0;
    check("satcnt_255", {24'd0, sat_cnt}, 32'd255);
    @(negedge clk);
    check("satcnt_hold", {24'd0, sat_cnt}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
